sha_msg_padder: RTL and testbench
=================================

// Module: sha_msg_padder
// PURPOSE
// - Sits between interface_control_logic's native stream and the SHA-256 compression core.
// - Packs 32-bit message words into 512-bit blocks and appends FIPS 180-4 padding: 0x80, zero fill, 64-bit bit length.
// - Emits complete blocks over a valid/ready handshake, flagging the first and last block of each message.
// PARAMETERS
// - WORD_W   32  Input word width; only 32 is supported.
// - BLK_W    512 Output block width; fixed for SHA-256.
// - LEN_W    64  Message bit-length counter width.
// PORTS
// - clk_i         in   1      Clock. One clock domain.
// - resetn_i      in   1      Reset, asynchronous, active-low.
// - start_i       in   1      Pulse: begin a new message. Acted on only in IDLE.
// - abort_i       in   1      Pulse: drop the current message and return to IDLE.
// - data_i        in   32     Message word, big-endian; byte 0 is data_i[31:24].
// - valid_i       in   1      data_i valid.
// - last_i        in   1      Qualifies data_i as the final word of the message.
// - last_bytes_i  in   3      Valid bytes in the final word: 0..4. 0 means an empty word (empty-message case). Values >4 are treated as 4.
// - ready_o       out  1      Padder accepts data_i this cycle.
// - blk_o         out  512    Block to the core; word k sits at [511-32k -: 32].
// - blk_valid_o   out  1      blk_o valid.
// - blk_ready_i   in   1      Core accepts blk_o.
// - blk_first_o   out  1      blk_o is the first block of the message.
// - blk_last_o    out  1      blk_o is the final, padded block of the message.
// - busy_o        out  1      High in every state other than IDLE.
// BEHAVIOUR
// - Reset values: ready_o, blk_valid_o, blk_first_o, blk_last_o and busy_o are 0; blk_o is all zeros; length counter is 0; state is IDLE.
// - FSM states: IDLE, FILL, EMIT, PAD.
//   - IDLE: ready_o=0. start_i clears blk_o, the word index and the length counter, sets first_pending, then goes to FILL.
//   - FILL: ready_o=1. Each accepted beat (valid_i & ready_o) writes word[idx] and adds 8*bytes to the length counter.
//     Non-last beats count 4 bytes. Counter wraps modulo 2^64.
//   - FILL, 16th non-last word accepted: go to EMIT with blk_last_o=0.
//   - FILL, last beat accepted: r = total bytes in this block, 0..64.
//     - Write 0x80 immediately after the final byte; zero every byte after it.
//     - r<=55: words 14/15 carry the length; EMIT with blk_last_o=1.
//     - 56<=r<=63: EMIT with blk_last_o=0, then PAD builds all zeros plus the length.
//     - r==64: EMIT with blk_last_o=0, then PAD builds 0x80 at byte 0, zeros, plus the length.
//   - EMIT: ready_o=0. blk_valid_o=1, and blk_o/blk_first_o/blk_last_o stay stable until blk_ready_i.
//     On the handshake, go to PAD if a pad block is pending, IDLE if blk_last_o was 1, otherwise FILL with idx=0 and a cleared block.
//   - PAD: a single cycle that builds the pad block, then EMIT with blk_last_o=1.
// - Latency: the beat that completes a block is accepted in cycle N; blk_valid_o is high in cycle N+1.
//   A pad block is valid 2 cycles after the preceding block's handshake.
// - blk_first_o=1 only on the first emitted block after start_i.
// - Empty message: a last beat with last_bytes_i=0 at idx=0 gives a single block 0x80000000, 0..0, length 0.
// - Simultaneous events:
//   - abort_i beats start_i.
//   - start_i outside IDLE is ignored.
//   - valid_i in IDLE/EMIT/PAD is not accepted, because ready_o=0.
// - abort_i in any state: next cycle state=IDLE and blk_valid_o=0; counter and index are cleared. Any block in flight is dropped mid-handshake.
// - Reset mid-operation: identical to abort, but asynchronous.
// CONFIGURATION
// - PADDER_HMAC_OFFSET_EN defined: adds input port hmac_i (1 bit), sampled with start_i.
//   - hmac_i=1 presets the length counter to 512, covering the key^ipad/opad block the core hashes separately.
//   - blk_first_o is forced to 0 for that message.
// - PADDER_HMAC_OFFSET_EN undefined: port hmac_i is absent; the counter always starts at 0.
// TESTING
// - "abc": one last beat 0x61626300, last_bytes=3 -> one block 61626380,0x0 x14,00000018; first=last=1.
// - 16 full words, then a last beat with last_bytes=0 -> block 1 is the data (last=0); block 2 is 80000000,0..0,00000200 (last=1).
// - 14 words, then a last beat with last_bytes=2 (r=58) -> block 1 carries 0x80 at byte 58 (last=0); block 2 is zeros with length 0x1D0 (last=1).
// - Hold blk_ready_i=0 for 10 cycles -> blk_o is stable and ready_o=0 throughout; on release, FILL resumes with the next beat.
// - abort_i in EMIT while blk_ready_i=0 -> next cycle blk_valid_o=0 and busy_o=0; a new "abc" then yields the same block as the first test.
// - PADDER_HMAC_OFFSET_EN with hmac_i=1 and "abc" -> length word 00000218; blk_first_o=0.

Source files
------------

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length, and hands
// complete blocks to the compression core over a valid/ready handshake.
// Optional build macro PADDER_HMAC_OFFSET_EN adds hmac_i, which presets the
// length counter to 512 and suppresses blk_first_o for that message.
module sha_msg_padder #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BLK_W  = 512,
  parameter int unsigned LEN_W  = 64
) (
  input  logic              clk_i,
  input  logic              resetn_i,
`ifdef PADDER_HMAC_OFFSET_EN
  input  logic              hmac_i,
`endif
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [2:0]        last_bytes_i,
  output logic              ready_o,
  output logic [BLK_W-1:0]  blk_o,
  output logic              blk_valid_o,
  input  logic              blk_ready_i,
  output logic              blk_first_o,
  output logic              blk_last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_PAD} state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               first_pend_q, first_pend_d;
  logic               blk_first_q, blk_first_d;
  logic               blk_last_q, blk_last_d;
  logic               pad_pend_q, pad_pend_d;
  logic               pad_mark_q, pad_mark_d;

  logic               hmac;
  logic [2:0]         nbytes;
  logic [WORD_W-1:0]  keep_mask;
  logic [WORD_W-1:0]  marker;
  logic [6:0]         fill_bytes;
  logic [LEN_W-1:0]   len_next;

`ifdef PADDER_HMAC_OFFSET_EN
  assign hmac = hmac_i;
`else
  assign hmac = 1'b0;
`endif

  // Final-word shaping: keep the valid bytes, place 0x80 right after them,
  // and compute the running length including this beat.
  always_comb begin
    nbytes     = (last_bytes_i > 3'd4) ? 3'd4 : last_bytes_i;
    keep_mask  = '1;
    marker     = '0;
    case (nbytes)
      3'd0:    begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
      3'd1:    begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
      3'd2:    begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
      3'd3:    begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
      default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h0000_0000; end
    endcase
    fill_bytes = {1'b0, idx_q, 2'b00} + {4'b0000, nbytes};
    if (last_i) len_next = len_q + LEN_W'({nbytes, 3'b000});
    else        len_next = len_q + LEN_W'(32);
  end

  // Next-state and datapath: block assembly, padding and handshake control.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    idx_d        = idx_q;
    len_d        = len_q;
    first_pend_d = first_pend_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    pad_pend_d   = pad_pend_q;
    pad_mark_d   = pad_mark_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          blk_d        = '0;
          idx_d        = '0;
          len_d        = hmac ? LEN_W'(512) : '0;
          first_pend_d = ~hmac;
          pad_pend_d   = 1'b0;
          pad_mark_d   = 1'b0;
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        if (valid_i) begin
          len_d = len_next;
          if (!last_i) begin
            for (int unsigned k = 0; k < 16; k++) begin
              if (k == 32'(idx_q)) blk_d[BLK_W-1-WORD_W*k -: WORD_W] = data_i;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d      = S_EMIT;
              blk_last_d   = 1'b0;
              blk_first_d  = first_pend_q;
              first_pend_d = 1'b0;
            end
          end else begin
            // Words after the final one are rewritten as zero; a full final
            // word pushes the 0x80 marker into the following word (or, at
            // word 15, into the separate pad block).
            for (int unsigned k = 0; k < 16; k++) begin
              if (k == 32'(idx_q))
                blk_d[BLK_W-1-WORD_W*k -: WORD_W] = (data_i & keep_mask) | marker;
              else if (k == 32'(idx_q) + 1 && nbytes == 3'd4)
                blk_d[BLK_W-1-WORD_W*k -: WORD_W] = 32'h8000_0000;
              else if (k > 32'(idx_q))
                blk_d[BLK_W-1-WORD_W*k -: WORD_W] = '0;
            end
            if (fill_bytes <= 7'd55) begin
              blk_d[LEN_W-1:0] = len_next;
              blk_last_d       = 1'b1;
              pad_pend_d       = 1'b0;
            end else begin
              blk_last_d       = 1'b0;
              pad_pend_d       = 1'b1;
              pad_mark_d       = (fill_bytes == 7'd64);
            end
            idx_d        = '0;
            blk_first_d  = first_pend_q;
            first_pend_d = 1'b0;
            state_d      = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (blk_ready_i) begin
          blk_first_d = 1'b0;
          blk_last_d  = 1'b0;
          if (pad_pend_q) begin
            state_d = S_PAD;
          end else if (blk_last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
            idx_d   = '0;
            blk_d   = '0;
          end
        end
      end
      S_PAD: begin
        blk_d                      = '0;
        blk_d[BLK_W-1 -: WORD_W]   = pad_mark_q ? 32'h8000_0000 : 32'h0000_0000;
        blk_d[LEN_W-1:0]           = len_q;
        blk_last_d                 = 1'b1;
        blk_first_d                = 1'b0;
        pad_pend_d                 = 1'b0;
        pad_mark_d                 = 1'b0;
        state_d                    = S_EMIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      len_d        = '0;
      first_pend_d = 1'b0;
      blk_first_d  = 1'b0;
      blk_last_d   = 1'b0;
      pad_pend_d   = 1'b0;
      pad_mark_d   = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      first_pend_q <= 1'b0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      pad_pend_q   <= 1'b0;
      pad_mark_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      first_pend_q <= first_pend_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
      pad_pend_q   <= pad_pend_d;
      pad_mark_q   <= pad_mark_d;
    end
  end

  assign ready_o     = (state_q == S_FILL);
  assign blk_valid_o = (state_q == S_EMIT);
  assign busy_o      = (state_q != S_IDLE);
  assign blk_o       = blk_q;
  assign blk_first_o = blk_first_q;
  assign blk_last_o  = blk_last_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench for sha_msg_padder: a byte-level padding model feeds a
// scoreboard of expected blocks, popped whenever a block handshake occurs.
module tb_sha_msg_padder;

  logic         clk = 1'b0;
  logic         resetn_i;
`ifdef PADDER_HMAC_OFFSET_EN
  logic         hmac_i;
`endif
  logic         start_i, abort_i;
  logic [31:0]  data_i;
  logic         valid_i, last_i;
  logic [2:0]   last_bytes_i;
  logic         ready_o;
  logic [511:0] blk_o;
  logic         blk_valid_o, blk_ready_i, blk_first_o, blk_last_o, busy_o;

  always #5 clk = ~clk;

  sha_msg_padder #(.WORD_W(32), .BLK_W(512), .LEN_W(64)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn_i),
`ifdef PADDER_HMAC_OFFSET_EN
    .hmac_i       (hmac_i),
`endif
    .start_i      (start_i),
    .abort_i      (abort_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .last_i       (last_i),
    .last_bytes_i (last_bytes_i),
    .ready_o      (ready_o),
    .blk_o        (blk_o),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_first_o  (blk_first_o),
    .blk_last_o   (blk_last_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  typedef struct {
    int unsigned nwords;
    int unsigned lbytes;
    int unsigned nblk;
    int unsigned bp;
  } vec_t;

  exp_t         exp_q[$];
  logic [7:0]   cur_q[$];
  logic [63:0]  msg_bytes;
  logic [63:0]  len_off;
  bit           msg_first;
  int unsigned  n_checks = 0;
  int unsigned  n_err    = 0;
  int unsigned  blk_cnt  = 0;
  int unsigned  bp_mode  = 0;
  vec_t         vecs[10];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: move the first 64 queued bytes into an expected block.
  function automatic void push_blk(input bit last);
    exp_t e;
    e.blk = '0;
    for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = cur_q[i];
    repeat (64) void'(cur_q.pop_front());
    e.first   = msg_first;
    e.last    = last;
    msg_first = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Back-pressure generator for the block side.
  initial begin
    blk_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       blk_ready_i = 1'b1;
        1:       blk_ready_i = 1'($urandom_range(0, 1));
        default: blk_ready_i = 1'b0;
      endcase
    end
  end

  // Scoreboard consumer: compare every block that completes a handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn_i && blk_valid_o) begin
        chk("ready_low_in_emit", ready_o, 1'b0);
        if (blk_ready_i) begin
          blk_cnt++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_block: got %h expected none", blk_o);
          end else begin
            n_checks--;
            e = exp_q.pop_front();
            chk("blk_data", blk_o, e.blk);
            chk("blk_first", blk_first_o, e.first);
            chk("blk_last", blk_last_o, e.last);
          end
        end
      end
    end
  end

  task automatic start_msg(input bit hm);
`ifdef PADDER_HMAC_OFFSET_EN
    hmac_i = hm;
`endif
    cur_q.delete();
    msg_bytes = '0;
    len_off   = hm ? 64'd512 : 64'd0;
    msg_first = ~hm;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input int unsigned b);
    int unsigned bb;
    int unsigned n;
    logic [63:0] bits;
    bb = (last && b < 4) ? b : 4;
    for (int unsigned j = 0; j < bb; j++) cur_q.push_back(d[31-8*j -: 8]);
    msg_bytes = msg_bytes + 64'(bb);
    if (!last) begin
      if (cur_q.size() == 64) push_blk(1'b0);
    end else begin
      bits = len_off + (msg_bytes << 3);
      cur_q.push_back(8'h80);
      while (cur_q.size() % 64 != 56) cur_q.push_back(8'h00);
      for (int j = 0; j < 8; j++) cur_q.push_back(bits[63-8*j -: 8]);
      while (cur_q.size() >= 64) push_blk(cur_q.size() == 64);
    end
    valid_i      = 1'b1;
    data_i       = d;
    last_i       = last;
    last_bytes_i = 3'(b);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_timeout", ready_o, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy_o, 1'b0);
  endtask

  initial begin
    int unsigned c0;
    vecs[0] = '{0, 0, 1, 0};
    vecs[1] = '{0, 3, 1, 1};
    vecs[2] = '{13, 3, 1, 0};
    vecs[3] = '{13, 4, 2, 1};
    vecs[4] = '{14, 0, 2, 0};
    vecs[5] = '{15, 3, 2, 1};
    vecs[6] = '{15, 4, 2, 0};
    vecs[7] = '{16, 0, 2, 1};
    vecs[8] = '{31, 2, 3, 1};
    vecs[9] = '{0, 7, 1, 0};

    resetn_i = 1'b0;
`ifdef PADDER_HMAC_OFFSET_EN
    hmac_i = 1'b0;
`endif
    start_i = 1'b0; abort_i = 1'b0; data_i = '0;
    valid_i = 1'b0; last_i = 1'b0; last_bytes_i = '0;
    #23;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_valid", blk_valid_o, 1'b0);
    chk("rst_first", blk_first_o, 1'b0);
    chk("rst_last", blk_last_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_blk", blk_o, '0);
    @(negedge clk);
    resetn_i = 1'b1;
    @(posedge clk);
    #1;

    // "abc": single block, valid one cycle after the last beat.
    start_msg(1'b0);
    send_beat(32'h6162_6300, 1'b1, 3);
    @(negedge clk);
    chk("abc_latency_valid", blk_valid_o, 1'b1);
    chk("abc_block", blk_o, {32'h6162_6380, 448'h0, 32'h0000_0018});
    chk("abc_first_last", {blk_first_o, blk_last_o}, 2'b11);
    wait_idle();

    // 16 full words then an empty last word: pad block 80000000..00000200.
    start_msg(1'b0);
    for (int i = 0; i < 16; i++) send_beat($urandom, 1'b0, 4);
    send_beat($urandom, 1'b1, 0);
    @(negedge clk);
    chk("w16_pad_block", blk_o, {32'h8000_0000, 448'h0, 32'h0000_0200});
    wait_idle();

    // 14 words + 2 bytes (r=58): pad block two cycles after handshake.
    start_msg(1'b0);
    for (int i = 0; i < 14; i++) send_beat($urandom, 1'b0, 4);
    send_beat(32'hAABB_CCDD, 1'b1, 2);
    @(negedge clk);
    chk("r58_blk1_valid_notlast", {blk_valid_o, blk_last_o}, 2'b10);
    chk("r58_marker_word", blk_o[63:32], 32'hAABB_8000);
    @(negedge clk);
    chk("r58_pad_cycle", {blk_valid_o, busy_o}, 2'b01);
    @(negedge clk);
    chk("r58_pad_valid_last", {blk_valid_o, blk_last_o}, 2'b11);
    chk("r58_pad_block", blk_o, {480'h0, 32'h0000_01D0});
    wait_idle();

    // Stall the core for 10 cycles after a full block.
    bp_mode = 2;
    start_msg(1'b0);
    for (int i = 0; i < 16; i++) send_beat($urandom, 1'b0, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", blk_valid_o, 1'b1);
      chk("stall_ready", ready_o, 1'b0);
      chk("stall_blk_stable", blk_o, exp_q[0].blk);
    end
    bp_mode = 0;
    send_beat(32'h0102_0304, 1'b1, 1);
    wait_idle();

    // Abort while the core holds off: block dropped, padder idles.
    bp_mode = 2;
    start_msg(1'b0);
    send_beat(32'h6162_6300, 1'b1, 3);
    @(negedge clk);
    chk("abort_pre_valid", blk_valid_o, 1'b1);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_valid", blk_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    bp_mode = 0;
    @(posedge clk);
    #1;
    start_msg(1'b0);
    send_beat(32'h6162_6300, 1'b1, 3);
    @(negedge clk);
    chk("abc_after_abort", blk_o, {32'h6162_6380, 448'h0, 32'h0000_0018});
    wait_idle();

    // abort beats a simultaneous start.
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", busy_o, 1'b0);

    // Table of message lengths around the padding boundaries.
    for (int v = 0; v < 10; v++) begin
      bp_mode = vecs[v].bp;
      c0 = blk_cnt;
      start_msg(1'b0);
      for (int unsigned i = 0; i < vecs[v].nwords; i++) send_beat($urandom, 1'b0, 4);
      send_beat($urandom, 1'b1, vecs[v].lbytes);
      wait_idle();
      chk($sformatf("vec%0d_nblk", v), 512'(blk_cnt - c0), 512'(vecs[v].nblk));
    end
    bp_mode = 0;

`ifdef PADDER_HMAC_OFFSET_EN
    start_msg(1'b1);
    send_beat(32'h6162_6300, 1'b1, 3);
    @(negedge clk);
    chk("hmac_len_word", blk_o[31:0], 32'h0000_0218);
    chk("hmac_first", blk_first_o, 1'b0);
    wait_idle();
`endif

    chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
